// File: rtl/ptw_rd_arb.sv
// Read-only AXI arbiter merging the instruction and data page-table walkers.
// Round-robin grant, a single outstanding transaction, R-beat count checking.
module ptw_rd_arb #(
   parameter int AW  = 32,
   parameter int IDW = 10,
   parameter int DW  = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [IDW-1:0] s0_arid,
   input  logic [AW-1:0]  s0_araddr,
   input  logic [7:0]     s0_arlen,
   input  logic [2:0]     s0_arsize,
   input  logic [1:0]     s0_arburst,
   input  logic           s0_arvalid,
   output logic           s0_arready,
   output logic [IDW-1:0] s0_rid,
   output logic [DW-1:0]  s0_rdata,
   output logic [1:0]     s0_rresp,
   output logic           s0_rlast,
   output logic           s0_rvalid,
   input  logic           s0_rready,
   input  logic [IDW-1:0] s1_arid,
   input  logic [AW-1:0]  s1_araddr,
   input  logic [7:0]     s1_arlen,
   input  logic [2:0]     s1_arsize,
   input  logic [1:0]     s1_arburst,
   input  logic           s1_arvalid,
   output logic           s1_arready,
   output logic [IDW-1:0] s1_rid,
   output logic [DW-1:0]  s1_rdata,
   output logic [1:0]     s1_rresp,
   output logic           s1_rlast,
   output logic           s1_rvalid,
   input  logic           s1_rready,
   output logic [IDW-1:0] m_arid,
   output logic [AW-1:0]  m_araddr,
   output logic [7:0]     m_arlen,
   output logic [2:0]     m_arsize,
   output logic [1:0]     m_arburst,
   output logic           m_arvalid,
   input  logic           m_arready,
   input  logic [IDW-1:0] m_rid,
   input  logic [DW-1:0]  m_rdata,
   input  logic [1:0]     m_rresp,
   input  logic           m_rlast,
   input  logic           m_rvalid,
   output logic           m_rready,
   output logic           proto_err
);

   typedef enum logic [1:0] {IDLE, AR, R} state_e;

   state_e     state_q, state_d;
   logic       ptr_q, ptr_d;
   logic       g_q, g_d;
   logic [7:0] len_q, len_d;
   logic [8:0] cnt_q, cnt_d;
   logic       perr_q, perr_d;

   logic in_ar, in_r;
   logic sg_arvalid, sg_rready;
   logic ar_hs, r_hs;

   // Handshake outputs are forced low while reset is held.
   assign in_ar = (state_q == AR) && !rst;
   assign in_r  = (state_q == R) && !rst;

   assign sg_arvalid = g_q ? s1_arvalid : s0_arvalid;
   assign sg_rready  = g_q ? s1_rready : s0_rready;

   assign m_arid    = g_q ? s1_arid : s0_arid;
   assign m_araddr  = g_q ? s1_araddr : s0_araddr;
   assign m_arlen   = g_q ? s1_arlen : s0_arlen;
   assign m_arsize  = g_q ? s1_arsize : s0_arsize;
   assign m_arburst = g_q ? s1_arburst : s0_arburst;
   assign m_arvalid = in_ar && sg_arvalid;

   assign s0_arready = in_ar && !g_q && m_arready;
   assign s1_arready = in_ar && g_q && m_arready;

   assign s0_rid   = m_rid;
   assign s0_rdata = m_rdata;
   assign s0_rresp = m_rresp;
   assign s0_rlast = m_rlast;
   assign s1_rid   = m_rid;
   assign s1_rdata = m_rdata;
   assign s1_rresp = m_rresp;
   assign s1_rlast = m_rlast;

   assign s0_rvalid = in_r && !g_q && m_rvalid;
   assign s1_rvalid = in_r && g_q && m_rvalid;
   assign m_rready  = in_r && sg_rready;

   assign ar_hs = m_arvalid && m_arready;
   assign r_hs  = m_rvalid && m_rready;

   assign proto_err = perr_q;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      g_d     = g_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      perr_d  = perr_q;
      unique case (state_q)
         IDLE: begin
            if (s0_arvalid || s1_arvalid) begin
               g_d     = (s0_arvalid && s1_arvalid) ? ptr_q : s1_arvalid;
               len_d   = g_d ? s1_arlen : s0_arlen;
               cnt_d   = '0;
               state_d = AR;
            end
         end
         AR: begin
            if (ar_hs)
               state_d = R;
            else if (!sg_arvalid)
               state_d = IDLE;
         end
         R: begin
            if (r_hs) begin
               cnt_d = cnt_q + 9'd1;
               // rlast must coincide exactly with beat index arlen
               if (m_rlast != (cnt_q == {1'b0, len_q}))
                  perr_d = 1'b1;
               if (m_rlast) begin
                  state_d = IDLE;
                  ptr_d   = ~g_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         g_q     <= 1'b0;
         len_q   <= '0;
         cnt_q   <= '0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         g_q     <= g_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         perr_q  <= perr_d;
      end
   end

endmodule

// File: tb/tb_ptw_rd_arb.sv
// Random walker/bus traffic against a transaction-level arbiter model.
// Random resets, backpressure, error responses and bad rlast placement.
module tb_ptw_rd_arb;

   localparam int AW   = 32;
   localparam int IDW  = 10;
   localparam int DW   = 32;
   localparam int NCYC = 4000;

   logic clk = 1'b0;
   logic rst;

   logic [IDW-1:0] s0_arid, s1_arid, m_arid, s0_rid, s1_rid, m_rid;
   logic [AW-1:0]  s0_araddr, s1_araddr, m_araddr;
   logic [7:0]     s0_arlen, s1_arlen, m_arlen;
   logic [2:0]     s0_arsize, s1_arsize, m_arsize;
   logic [1:0]     s0_arburst, s1_arburst, m_arburst;
   logic           s0_arvalid, s1_arvalid, m_arvalid;
   logic           s0_arready, s1_arready, m_arready;
   logic [DW-1:0]  s0_rdata, s1_rdata, m_rdata;
   logic [1:0]     s0_rresp, s1_rresp, m_rresp;
   logic           s0_rlast, s1_rlast, m_rlast;
   logic           s0_rvalid, s1_rvalid, m_rvalid;
   logic           s0_rready, s1_rready, m_rready;
   logic           proto_err;

   always #5 clk = ~clk;

   ptw_rd_arb #(.AW(AW), .IDW(IDW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen),
      .s0_arsize(s0_arsize), .s0_arburst(s0_arburst),
      .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
      .s0_rid(s0_rid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
      .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
      .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen),
      .s1_arsize(s1_arsize), .s1_arburst(s1_arburst),
      .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
      .s1_rid(s1_rid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
      .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
      .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
      .m_arsize(m_arsize), .m_arburst(m_arburst),
      .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
      .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .proto_err(proto_err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // walker requests, held until accepted or deliberately dropped
   logic           w_pend[2];
   logic [IDW-1:0] w_id[2];
   logic [AW-1:0]  w_addr[2];
   logic [7:0]     w_len[2];
   logic [2:0]     w_size[2];
   logic [1:0]     w_burst[2];

   // bus responder
   int             b_left;
   logic           b_valid, b_last;
   logic [DW-1:0]  b_data;
   logic [1:0]     b_resp;
   logic [IDW-1:0] b_id;

   // reference model: phase 0 idle, 1 address, 2 data
   int ph, mlen, mbeat;
   bit mg, mptr, mperr;

   task automatic drive();
      s0_arvalid = w_pend[0]; s0_arid = w_id[0]; s0_araddr = w_addr[0];
      s0_arlen = w_len[0]; s0_arsize = w_size[0]; s0_arburst = w_burst[0];
      s1_arvalid = w_pend[1]; s1_arid = w_id[1]; s1_araddr = w_addr[1];
      s1_arlen = w_len[1]; s1_arsize = w_size[1]; s1_arburst = w_burst[1];
      m_rvalid = b_valid; m_rdata = b_data; m_rresp = b_resp;
      m_rlast = b_last; m_rid = b_id;
   endtask

   initial begin
      logic sav[2], srr[2], sarr[2], srv[2];
      logic hs_ar[2];
      logic hs_mar, hs_mr, inar, inr;
      logic [7:0] cap_len;
      logic [IDW-1:0] cap_id, grid;
      logic [DW-1:0] grdata;
      logic [1:0] grresp;
      logic grlast;
      bit dropped;

      for (int p = 0; p < 2; p++) begin
         w_pend[p] = 0; w_id[p] = '0; w_addr[p] = '0;
         w_len[p] = '0; w_size[p] = '0; w_burst[p] = '0;
      end
      b_left = 0; b_valid = 0; b_last = 0; b_data = '0; b_resp = '0; b_id = '0;
      m_arready = 0; s0_rready = 0; s1_rready = 0;
      ph = 0; mg = 0; mptr = 0; mperr = 0; mlen = 0; mbeat = 0;
      rst = 1;
      drive();
      @(posedge clk); #1;

      for (int c = 0; c < NCYC; c++) begin
         @(negedge clk);
         sav[0] = s0_arvalid;  sav[1] = s1_arvalid;
         srr[0] = s0_rready;   srr[1] = s1_rready;
         sarr[0] = s0_arready; sarr[1] = s1_arready;
         srv[0] = s0_rvalid;   srv[1] = s1_rvalid;
         inar = !rst && ph == 1;
         inr  = !rst && ph == 2;

         check("m_arvalid", m_arvalid, inar && sav[mg]);
         check("s0_arready", sarr[0], inar && !mg && m_arready);
         check("s1_arready", sarr[1], inar && mg && m_arready);
         check("m_rready", m_rready, inr && srr[mg]);
         check("s0_rvalid", srv[0], inr && !mg && m_rvalid);
         check("s1_rvalid", srv[1], inr && mg && m_rvalid);
         check("proto_err", proto_err, mperr);
         if (inar && sav[mg]) begin
            check("m_araddr", m_araddr, w_addr[mg]);
            check("m_arid", m_arid, w_id[mg]);
            check("m_arlen", m_arlen, w_len[mg]);
            check("m_arsize", m_arsize, w_size[mg]);
            check("m_arburst", m_arburst, w_burst[mg]);
         end
         if (inr && m_rvalid) begin
            grid   = mg ? s1_rid : s0_rid;
            grdata = mg ? s1_rdata : s0_rdata;
            grresp = mg ? s1_rresp : s0_rresp;
            grlast = mg ? s1_rlast : s0_rlast;
            check("rid", grid, m_rid);
            check("rdata", grdata, m_rdata);
            check("rresp", grresp, m_rresp);
            check("rlast", grlast, m_rlast);
         end

         hs_ar[0] = sav[0] && sarr[0];
         hs_ar[1] = sav[1] && sarr[1];
         hs_mar  = m_arvalid && m_arready;
         hs_mr   = m_rvalid && m_rready;
         cap_len = m_arlen;
         cap_id  = m_arid;

         // advance the model using ideal handshakes at the coming edge
         if (rst) begin
            ph = 0; mptr = 0; mperr = 0; mg = 0;
         end else if (ph == 0) begin
            if (sav[0] || sav[1]) begin
               mg = (sav[0] && sav[1]) ? mptr : sav[1];
               mlen = int'(w_len[mg]);
               mbeat = 0;
               ph = 1;
            end
         end else if (ph == 1) begin
            if (sav[mg] && m_arready) ph = 2;
            else if (!sav[mg]) ph = 0;
         end else begin
            if (m_rvalid && srr[mg]) begin
               if (m_rlast != (mbeat == mlen)) mperr = 1;
               mbeat++;
               if (m_rlast) begin
                  ph = 0;
                  mptr = !mg;
               end
            end
         end

         @(posedge clk); #1;
         rst = (c < 2) || ($urandom_range(0, 299) == 0);

         for (int p = 0; p < 2; p++) begin
            dropped = 0;
            if (hs_ar[p]) w_pend[p] = 0;
            else if (w_pend[p] && $urandom_range(0, 99) == 0) begin
               w_pend[p] = 0;
               dropped = 1;
            end
            if (!w_pend[p] && !dropped && c >= 2 &&
                $urandom_range(0, 2) == 0) begin
               w_pend[p]  = 1;
               w_id[p]    = IDW'($urandom);
               w_addr[p]  = AW'($urandom);
               w_len[p]   = 8'($urandom_range(0, 3));
               w_size[p]  = 3'($urandom_range(0, 3));
               w_burst[p] = 2'($urandom_range(0, 2));
            end
         end

         if (hs_mar) begin
            b_left = int'(cap_len) + 1;
            b_id = cap_id;
            if ($urandom_range(0, 7) == 0) b_left = $urandom_range(1, 4);
         end
         if (hs_mr) begin
            b_left--;
            b_valid = 0;
         end
         if (b_left > 0 && !b_valid && $urandom_range(0, 3) != 0) begin
            b_valid = 1;
            b_data  = DW'($urandom);
            b_resp  = 2'($urandom_range(0, 3));
            b_last  = (b_left == 1);
         end
         if (rst) begin
            b_left = 0;
            b_valid = 0;
         end

         m_arready = ($urandom_range(0, 4) < 3);
         s0_rready = ($urandom_range(0, 3) != 0);
         s1_rready = ($urandom_range(0, 3) != 0);
         drive();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ptw_rd_arb.md
PTW_RD_ARB -- requirements
Module: ptw_rd_arb

Interface
REQ-001 Parameters: AW, default 32, AXI address width; IDW, default 10, AXI ID width; DW, default 32, read data width.
REQ-002 Ports: clk  in  1  clock. Reset is synchronous and active-high; the reset port is rst.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 sN_arid/araddr/arlen/arsize/arburst/arvalid  in  IDW/AW/8/3/2/1  AR channel from page-table walker N, where N is 0 (instruction MMU) or 1 (data MMU).
REQ-005 sN_arready  out  1  AR accept to walker N.
REQ-006 sN_rid/rdata/rresp/rlast/rvalid  out  IDW/DW/2/1/1  R channel to walker N.
REQ-007 sN_rready  in  1  R accept from walker N.
REQ-008 m_arid/araddr/arlen/arsize/arburst/arvalid  out  IDW/AW/8/3/2/1  merged AR channel to the bus.
REQ-009 m_arready  in  1  bus AR accept.
REQ-010 m_rid/rdata/rresp/rlast/rvalid  in  IDW/DW/2/1/1  bus R channel.
REQ-011 m_rready  out  1  R accept to the bus.
REQ-012 proto_err  out  1  sticky flag for an R-beat count violation.

Function
REQ-013 The block is read-only and SHALL allow exactly one outstanding transaction at a time.
REQ-014 FSM states SHALL be IDLE, AR and R.
REQ-015 IDLE: if any sN_arvalid is high, the block SHALL latch grant index g and arlen, clear the beat counter, and move to AR on the next cycle. All AR/R handshake outputs are 0 in IDLE.
REQ-016 Arbitration SHALL be round-robin via a 1-bit pointer ptr. With both requests active, grant goes to port ptr. With one request active, grant goes to that port.
REQ-017 AR: m_ar* SHALL equal sg_ar* combinationally, m_arvalid SHALL equal sg_arvalid, and sg_arready SHALL equal m_arready. The other port's arready SHALL be 0.
REQ-018 AR: on m_arvalid && m_arready the FSM SHALL move to R.
REQ-019 AR: if sg_arvalid drops before the handshake (protocol violation), the FSM SHALL return to IDLE with ptr unchanged.
REQ-020 R: sg_r* SHALL equal m_r*, sg_rvalid SHALL equal m_rvalid, and m_rready SHALL equal sg_rready. The non-granted port's rvalid SHALL be 0.
REQ-021 Each R handshake SHALL increment the 9-bit beat counter.
REQ-022 On an R handshake with m_rlast=1, the FSM SHALL go to IDLE and set ptr to ~g.
REQ-023 m_rready SHALL be 0 outside R; R beats arriving in IDLE or AR stay stalled on the bus.
REQ-024 rresp SHALL pass through unmodified, including SLVERR/DECERR; an error response does not change FSM flow.
REQ-025 proto_err SHALL be set if, in R, a beat with rlast=1 has counter != latched arlen, or a beat with rlast=0 has counter == arlen. It stays set until rst; the transaction still completes on rlast.
REQ-026 Latency: sN_arvalid rise in IDLE to m_arvalid is exactly 1 cycle. After R completes, a pending request SHALL reach m_arvalid 2 cycles after the last R handshake (R->IDLE->AR).
REQ-027 A new request on the non-granted port during AR/R SHALL be held (arready=0) and not lost. That port wins the next arbitration via ptr.

Reset
REQ-028 On rst=1 at a clock edge: state=IDLE, ptr=0, g=0, beat counter=0, arlen latch=0, proto_err=0.
REQ-029 During and immediately after reset, m_arvalid, m_rready, s0/s1_arready and s0/s1_rvalid SHALL be 0.
REQ-030 Reset asserted mid-AR or mid-R SHALL abandon the transaction without further handshakes.

Verification
REQ-031 Single request: s0 araddr=0x8000_1000, arlen=0 -> m_arvalid cycle+1 with same address; one R beat rdata=0x0000_00CF with rlast -> s0_rvalid; s1 sees nothing; IDLE after.
REQ-032 Simultaneous s0/s1 requests after reset -> s0 served first, then s1; m_arvalid for s1 exactly 2 cycles after s0's last R handshake; repeated contention alternates s1, s0.
REQ-033 Backpressure: m_arready low 5 cycles, s1_rready low 3 cycles -> m_ar* held stable, R beat held with m_rready=0, no loss or duplication.
REQ-034 rresp=2'b10 on the s1 read -> forwarded to s1_rresp unchanged; proto_err stays 0; next request served normally.
REQ-035 arlen=1 but bus returns rlast on the first beat -> proto_err=1 sticky, FSM to IDLE; proto_err clears only on rst.
REQ-036 rst pulsed while in R with an s0 beat pending -> all outputs 0 next cycle, state IDLE, ptr=0; a following s1 request is served.
